// File: rtl/vga_layout_pkg.sv
// Shared screen layout for the map/HUD translators.
// Includes the map origin, tile geometry and HUD box origins.
package vga_layout_pkg;

  localparam int MAP_X0   = 95;
  localparam int MAP_Y0   = 15;
  localparam int TILE     = 30;
  localparam int MAP_N    = 15;
  localparam int PORTRAIT = 90;
  localparam int HEART    = 20;
  localparam int MAP_SPAN = MAP_N * TILE;
  localparam int SCR_W    = 640;
  localparam int SCR_H    = 480;

  localparam logic [4:0] HUD_P15 = 5'd15;
  localparam logic [4:0] HUD_P16 = 5'd16;
  localparam logic [4:0] HUD_P17 = 5'd17;
  localparam logic [4:0] HUD_P18 = 5'd18;

  localparam int HUD_BOXES = 16;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_MAP  = 2'd1,
    REG_HUD  = 2'd2
  } region_t;

  typedef logic [9:0] coord_t;

  // Index = panel*4 + slot; slot 0 is the portrait, 1..3 the hearts
  localparam coord_t HUD_OX [HUD_BOXES] = '{
    10'd4,   10'd14,  10'd38,  10'd62,
    10'd548, 10'd558, 10'd582, 10'd606,
    10'd4,   10'd14,  10'd38,  10'd62,
    10'd548, 10'd558, 10'd582, 10'd606
  };

  localparam coord_t HUD_OY [HUD_BOXES] = '{
    10'd121, 10'd216, 10'd216, 10'd216,
    10'd254, 10'd349, 10'd349, 10'd349,
    10'd254, 10'd349, 10'd349, 10'd349,
    10'd121, 10'd216, 10'd216, 10'd216
  };

  localparam logic [8:0] TILE_BASE [16] = '{
    9'd0,   9'd30,  9'd60,  9'd90,
    9'd120, 9'd150, 9'd180, 9'd210,
    9'd240, 9'd270, 9'd300, 9'd330,
    9'd360, 9'd390, 9'd420, 9'd0
  };

  function automatic int box_edge(input int i);
    return (i % 4 == 0) ? PORTRAIT : HEART;
  endfunction

  function automatic logic in_span(
    input coord_t p,
    input coord_t o,
    input int     e
  );
    return (p >= o) &&
      ({1'b0, p} < ({1'b0, o} + 11'(e)));
  endfunction

  function automatic logic [3:0] tile_quot(
    input logic [8:0] d
  );
    logic [3:0] q;
    q = '0;
    for (int k = 1; k < MAP_N; k++) begin
      if (d >= 9'(k * TILE)) q = q + 4'd1;
    end
    return q;
  endfunction

endpackage

// File: rtl/vga_pixel_to_maploc_if.sv
// Pixel stream in, owning map/HUD location out.
// master = raster side, slave = translator.
interface vga_pixel_to_maploc_if;
  import vga_layout_pkg::*;

  logic       pix_valid;
  coord_t     pix_x;
  coord_t     pix_y;
  logic       out_valid;
  region_t    region;
  logic [4:0] loc_x;
  logic [4:0] loc_y;
  logic [6:0] off_x;
  logic [6:0] off_y;

  modport master (
    output pix_valid, pix_x, pix_y,
    input  out_valid, region,
    input  loc_x, loc_y, off_x, off_y
  );

  modport slave (
    input  pix_valid, pix_x, pix_y,
    output out_valid, region,
    output loc_x, loc_y, off_x, off_y
  );

endinterface

// File: rtl/vga_pixel_to_maploc_hud_hit.sv
// Combinational test of a pixel against the 16 HUD boxes.
// Boxes are disjoint, so at most one match fires.
module vga_hud_hit
  import vga_layout_pkg::*;
(
  input  coord_t     x,
  input  coord_t     y,
  output logic       hit,
  output logic [4:0] code,
  output logic [1:0] slot,
  output logic [6:0] off_x,
  output logic [6:0] off_y
);

  always_comb begin
    hit   = 1'b0;
    code  = '0;
    slot  = '0;
    off_x = '0;
    off_y = '0;
    for (int i = 0; i < HUD_BOXES; i++) begin
      if (in_span(x, HUD_OX[i], box_edge(i)) &&
          in_span(y, HUD_OY[i], box_edge(i))) begin
        hit   = 1'b1;
        code  = HUD_P15 + 5'(i / 4);
        slot  = 2'(i % 4);
        off_x = 7'(x - HUD_OX[i]);
        off_y = 7'(y - HUD_OY[i]);
      end
    end
  end

endmodule

// File: rtl/vga_pixel_to_maploc.sv
// 3-stage pixel -> owning map tile / HUD element translator.
// Stage 1 region test, stage 2 quotient, stage 3 remainder.
module vga_pixel_to_maploc
  import vga_layout_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  vga_pixel_to_maploc_if.slave bus
);

  logic [10:0] dx, dy;
  logic        in_map, on_scr;
  logic        h_hit;
  logic [4:0]  h_code;
  logic [1:0]  h_slot;
  logic [6:0]  h_ox, h_oy;
  region_t     reg_d;

  assign dx = {1'b0, bus.pix_x} - 11'(MAP_X0);
  assign dy = {1'b0, bus.pix_y} - 11'(MAP_Y0);

  assign in_map = !dx[10] && (dx[9:0] < 10'(MAP_SPAN))
               && !dy[10] && (dy[9:0] < 10'(MAP_SPAN));
  assign on_scr = (bus.pix_x < 10'(SCR_W))
               && (bus.pix_y < 10'(SCR_H));

  vga_hud_hit u_hud (
    .x     (bus.pix_x),
    .y     (bus.pix_y),
    .hit   (h_hit),
    .code  (h_code),
    .slot  (h_slot),
    .off_x (h_ox),
    .off_y (h_oy)
  );

  always_comb begin
    reg_d = REG_NONE;
    unique case (1'b1)
      in_map:          reg_d = REG_MAP;
      h_hit && on_scr: reg_d = REG_HUD;
      default:         reg_d = REG_NONE;
    endcase
  end

  logic       s1_valid;
  region_t    s1_region;
  logic [8:0] s1_dx, s1_dy;
  logic [4:0] s1_code;
  logic [1:0] s1_slot;
  logic [6:0] s1_hx, s1_hy;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_region <= REG_NONE;
      s1_dx     <= '0;
      s1_dy     <= '0;
      s1_code   <= '0;
      s1_slot   <= '0;
      s1_hx     <= '0;
      s1_hy     <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      if (bus.pix_valid) begin
        s1_region <= reg_d;
        s1_dx     <= dx[8:0];
        s1_dy     <= dy[8:0];
        s1_code   <= h_code;
        s1_slot   <= h_slot;
        s1_hx     <= h_ox;
        s1_hy     <= h_oy;
      end
    end
  end

  logic       s2_valid;
  region_t    s2_region;
  logic [3:0] s2_qx, s2_qy;
  logic [8:0] s2_dx, s2_dy;
  logic [4:0] s2_code;
  logic [1:0] s2_slot;
  logic [6:0] s2_hx, s2_hy;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_region <= REG_NONE;
      s2_qx     <= '0;
      s2_qy     <= '0;
      s2_dx     <= '0;
      s2_dy     <= '0;
      s2_code   <= '0;
      s2_slot   <= '0;
      s2_hx     <= '0;
      s2_hy     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_region <= s1_region;
        s2_qx     <= tile_quot(s1_dx);
        s2_qy     <= tile_quot(s1_dy);
        s2_dx     <= s1_dx;
        s2_dy     <= s1_dy;
        s2_code   <= s1_code;
        s2_slot   <= s1_slot;
        s2_hx     <= s1_hx;
        s2_hy     <= s1_hy;
      end
    end
  end

  logic       o_valid;
  region_t    o_region;
  logic [4:0] o_lx, o_ly;
  logic [6:0] o_ox, o_oy;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid  <= 1'b0;
      o_region <= REG_NONE;
      o_lx     <= '0;
      o_ly     <= '0;
      o_ox     <= '0;
      o_oy     <= '0;
    end else begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        unique case (s2_region)
          REG_MAP: begin
            o_region <= REG_MAP;
            o_lx     <= {1'b0, s2_qx};
            o_ly     <= {1'b0, s2_qy};
            o_ox     <= 7'(s2_dx - TILE_BASE[s2_qx]);
            o_oy     <= 7'(s2_dy - TILE_BASE[s2_qy]);
          end
          REG_HUD: begin
            o_region <= REG_HUD;
            o_lx     <= s2_code;
            o_ly     <= {3'b000, s2_slot};
            o_ox     <= s2_hx;
            o_oy     <= s2_hy;
          end
          default: begin
            o_region <= REG_NONE;
            o_lx     <= '0;
            o_ly     <= '0;
            o_ox     <= '0;
            o_oy     <= '0;
          end
        endcase
      end
    end
  end

  assign bus.out_valid = o_valid;
  assign bus.region    = o_region;
  assign bus.loc_x     = o_lx;
  assign bus.loc_y     = o_ly;
  assign bus.off_x     = o_ox;
  assign bus.off_y     = o_oy;

endmodule

// File: tb/tb_vga_pixel_to_maploc.sv
// Directed bench: single pixels, boundaries, HUD,
// streaming, mid-stream reset and a round-trip sweep.
module tb_vga_pixel_to_maploc;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  logic [25:0] last_w;
  logic [25:0] sw [8];
  logic        sv [8];
  int          sx [8];
  int          sy [8];

  int hx [16] = '{4, 14, 38, 62, 548, 558, 582, 606,
                  4, 14, 38, 62, 548, 558, 582, 606};
  int hy [16] = '{121, 216, 216, 216, 254, 349, 349, 349,
                  254, 349, 349, 349, 121, 216, 216, 216};

  vga_pixel_to_maploc_if bus ();

  vga_pixel_to_maploc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] w(
    input int r, input int lx, input int ly,
    input int ox, input int oy
  );
    return {2'(r), 5'(lx), 5'(ly), 7'(ox), 7'(oy)};
  endfunction

  function automatic logic [26:0] sample();
    return {bus.out_valid, 2'(bus.region),
            bus.loc_x, bus.loc_y, bus.off_x, bus.off_y};
  endfunction

  task automatic check(
    input string tag,
    input logic [26:0] obs,
    input logic [26:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic pix_check(
    input string tag, input int x, input int y,
    input int r, input int lx, input int ly,
    input int ox, input int oy
  );
    logic [25:0] e;
    e = w(r, lx, ly, ox, oy);
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x = 10'(x);
    bus.pix_y = 10'(y);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check(tag, sample(), {1'b1, e});
    last_w = e;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_x = '0;
    bus.pix_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", sample(), 27'd0);
    reset = 1'b0;

    pix_check("map_origin", 95, 15, 1, 0, 0, 0, 0);
    pix_check("map_last", 544, 464, 1, 14, 14, 29, 29);
    pix_check("map_125_44", 125, 44, 1, 1, 0, 0, 29);
    pix_check("left_edge", 94, 15, 0, 0, 0, 0, 0);
    pix_check("right_edge", 545, 100, 0, 0, 0, 0, 0);
    pix_check("offscreen", 700, 10, 0, 0, 0, 0, 0);
    pix_check("offscreen_y", 600, 1000, 0, 0, 0, 0, 0);
    pix_check("hud15_org", 4, 121, 2, 15, 0, 0, 0);
    pix_check("hud16_h2", 583, 350, 2, 16, 2, 1, 1);
    pix_check("hud15_far", 93, 210, 2, 15, 0, 89, 89);
    pix_check("heart_gap", 34, 216, 0, 0, 0, 0, 0);
    pix_check("hud16_far", 637, 343, 2, 16, 0, 89, 89);
    pix_check("hud17_h3", 81, 368, 2, 17, 3, 19, 19);

    sv[0] = 1; sx[0] = 95;  sy[0] = 15;
    sw[0] = w(1, 0, 0, 0, 0);
    sv[1] = 0; sx[1] = 4;   sy[1] = 121;
    sw[1] = '0;
    sv[2] = 1; sx[2] = 583; sy[2] = 350;
    sw[2] = w(2, 16, 2, 1, 1);
    sv[3] = 1; sx[3] = 125; sy[3] = 44;
    sw[3] = w(1, 1, 0, 0, 29);
    sv[4] = 1; sx[4] = 544; sy[4] = 464;
    sw[4] = w(1, 14, 14, 29, 29);
    sv[5] = 0; sx[5] = 548; sy[5] = 121;
    sw[5] = '0;
    sv[6] = 1; sx[6] = 93;  sy[6] = 210;
    sw[6] = w(2, 15, 0, 89, 89);
    sv[7] = 1; sx[7] = 34;  sy[7] = 216;
    sw[7] = w(0, 0, 0, 0, 0);

    @(negedge clk);
    for (int j = 0; j < 11; j++) begin
      if (j >= 3) begin
        if (sv[j-3]) last_w = sw[j-3];
        check($sformatf("stream_%0d", j - 3), sample(),
              {sv[j-3], last_w});
      end
      if (j < 8) begin
        bus.pix_valid = sv[j];
        bus.pix_x = 10'(sx[j]);
        bus.pix_y = 10'(sy[j]);
      end else begin
        bus.pix_valid = 1'b0;
      end
      @(negedge clk);
    end

    pix_check("pre_flush", 544, 464, 1, 14, 14, 29, 29);
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x = 10'd95;
    bus.pix_y = 10'd15;
    @(negedge clk);
    bus.pix_x = 10'd125;
    bus.pix_y = 10'd44;
    @(negedge clk);
    bus.pix_x = 10'd4;
    bus.pix_y = 10'd121;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.pix_valid = 1'b0;
    check("flush_reset", sample(), 27'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("flush_drain_%0d", k), sample(), 27'd0);
    end

    for (int ly = 0; ly < 15; ly++) begin
      for (int lx = 0; lx < 15; lx++) begin
        pix_check($sformatf("rt_map_%0d_%0d", lx, ly),
                  95 + 30 * lx, 15 + 30 * ly,
                  1, lx, ly, 0, 0);
      end
    end
    for (int b = 0; b < 16; b++) begin
      pix_check($sformatf("rt_hud_%0d", b),
                hx[b], hy[b], 2, 15 + b / 4, b % 4, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
